// File: rtl/rsa_modexp_decryptor_if.sv
// Handshake bundle for rsa_modexp_decryptor: key load, ciphertext in, plaintext out.
// slave = decryptor side, master = key/ciphertext source and plaintext sink side.
interface rsa_modexp_decryptor_if #(
    parameter int W = 8
);
    logic         key_valid;
    logic [W-1:0] key_n;
    logic [W-1:0] key_d;
    logic         key_ready;
    logic         key_err;
    logic         key_loaded;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         busy;

    modport slave (
        input  key_valid, key_n, key_d, in_valid, in_data, out_ready,
        output key_ready, key_err, key_loaded, in_ready, out_valid, out_data, busy
    );

    modport master (
        output key_valid, key_n, key_d, in_valid, in_data, out_ready,
        input  key_ready, key_err, key_loaded, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/rsa_modexp_decryptor.sv
// RSA decryptor m = c^d mod n: right-to-left square-and-multiply over bit-serial
// interleaved modular multipliers. Optional macro MODEXP_EARLY_EXIT_EN stops EXP after msb(d).
module rsa_modexp_decryptor #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rsa_modexp_decryptor_if.slave io
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int AW = W + 2;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, REDUCE, EXP, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  base_q, base_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [AW-1:0] acc_b_q, acc_b_d;
    logic [AW-1:0] acc_r_q, acc_r_d;
    logic          key_ready_q, key_ready_d;
    logic          key_err_q, key_err_d;
    logic          key_loaded_q, key_loaded_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] a_idx;
    logic          b_a_bit;
    logic [W-1:0]  b_operand;
    logic [AW-1:0] acc_b_step, acc_r_step;
    logic          last_step, last_bit;

    // One step of interleaved modmul; acc < n and b < n keep the sum below 3n.
    function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                              input logic          a_bit,
                                              input logic [W-1:0]  b,
                                              input logic [W-1:0]  n);
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = AW'(n);
        t  = {acc[AW-2:0], 1'b0} + (a_bit ? AW'(b) : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    // The base unit doubles as the c mod n reducer during REDUCE (operand b = 1).
    assign a_idx      = CW'(W - 1) - step_q;
    assign b_a_bit    = (state_q == REDUCE) ? c_q[a_idx] : base_q[a_idx];
    assign b_operand  = (state_q == REDUCE) ? ONE : base_q;
    assign acc_b_step = mm_step(acc_b_q, b_a_bit, b_operand, n_q);
    assign acc_r_step = mm_step(acc_r_q, result_q[a_idx], base_q, n_q);
    assign last_step  = (step_q == CW'(W - 1));

`ifdef MODEXP_EARLY_EXIT_EN
    assign last_bit = (bit_q == CW'(W - 1)) || ((d_q >> (32'(bit_q) + 32'd1)) == '0);
`else
    assign last_bit = (bit_q == CW'(W - 1));
`endif

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        bit_d        = bit_q;
        n_d          = n_q;
        d_d          = d_q;
        c_d          = c_q;
        base_d       = base_q;
        result_d     = result_q;
        out_data_d   = out_data_q;
        acc_b_d      = acc_b_q;
        acc_r_d      = acc_r_q;
        key_err_d    = key_err_q;
        key_loaded_d = key_loaded_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            IDLE: begin
                if (io.key_valid && key_ready_q) begin
                    if (io.key_n < W'(2)) begin
                        key_err_d    = 1'b1;
                        key_loaded_d = 1'b0;
                    end else begin
                        n_d          = io.key_n;
                        d_d          = io.key_d;
                        key_err_d    = 1'b0;
                        key_loaded_d = 1'b1;
                    end
                end else if (io.in_valid && in_ready_q) begin
                    c_d      = io.in_data;
                    result_d = ONE;
                    acc_b_d  = '0;
                    acc_r_d  = '0;
                    step_d   = '0;
                    state_d  = REDUCE;
                end
            end
            REDUCE: begin
                acc_b_d = acc_b_step;
                step_d  = step_q + CW'(1);
                if (last_step) begin
                    base_d  = acc_b_step[W-1:0];
                    acc_b_d = '0;
                    step_d  = '0;
                    bit_d   = '0;
`ifdef MODEXP_EARLY_EXIT_EN
                    state_d = (d_q == '0) ? DONE : EXP;
`else
                    state_d = EXP;
`endif
                end
            end
            EXP: begin
                acc_b_d = acc_b_step;
                acc_r_d = acc_r_step;
                step_d  = step_q + CW'(1);
                if (last_step) begin
                    base_d = acc_b_step[W-1:0];
                    if (d_q[bit_q]) result_d = acc_r_step[W-1:0];
                    acc_b_d = '0;
                    acc_r_d = '0;
                    step_d  = '0;
                    bit_d   = bit_q + CW'(1);
                    if (last_bit) state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle publishes the result; it then holds until the sink takes it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result_q;
                end else if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        key_ready_d = (state_d == IDLE);
        in_ready_d  = (state_d == IDLE) && key_loaded_d;
        busy_d      = (state_d == REDUCE) || (state_d == EXP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            bit_q        <= '0;
            n_q          <= '0;
            d_q          <= '0;
            c_q          <= '0;
            base_q       <= '0;
            result_q     <= '0;
            out_data_q   <= '0;
            acc_b_q      <= '0;
            acc_r_q      <= '0;
            key_ready_q  <= 1'b0;
            key_err_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            bit_q        <= bit_d;
            n_q          <= n_d;
            d_q          <= d_d;
            c_q          <= c_d;
            base_q       <= base_d;
            result_q     <= result_d;
            out_data_q   <= out_data_d;
            acc_b_q      <= acc_b_d;
            acc_r_q      <= acc_r_d;
            key_ready_q  <= key_ready_d;
            key_err_q    <= key_err_d;
            key_loaded_q <= key_loaded_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign io.key_ready  = key_ready_q;
    assign io.key_err    = key_err_q;
    assign io.key_loaded = key_loaded_q;
    assign io.in_ready   = in_ready_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_data   = out_data_q;
    assign io.busy       = busy_q;
endmodule

// File: tb/tb_rsa_modexp_decryptor.sv
// Self-checking bench for rsa_modexp_decryptor: directed scenarios plus random keys
// checked against a plain-arithmetic modular exponentiation model.
module tb_rsa_modexp_decryptor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rsa_modexp_decryptor_if #(.W(W)) bus ();

    rsa_modexp_decryptor #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    function automatic int ref_modexp(int c, int d, int n);
        longint r = 1;
        longint b = c % n;
        for (int i = 0; i < d; i++) r = (r * b) % n;
        return int'(r % n);
    endfunction

    function automatic int ref_latency(int d);
`ifdef MODEXP_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < W; i++) if (d[i]) msb = i;
        if (msb < 0) return W + 1;
        return W + W * (msb + 1) + 1;
`else
        return W + W * W + 1 + (d & 0);
`endif
    endfunction

    task automatic load_key(input logic [W-1:0] n, input logic [W-1:0] d);
        int guard = 0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_n     = n;
        bus.key_d     = d;
        while (bus.key_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL key_load_timeout key_ready=%b required 1", bus.key_ready);
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic do_decrypt(input logic [W-1:0] c, input int exp_lat,
                              output logic [W-1:0] got, output int lat, output bit busy_ok);
        int guard = 0;
        got = '0; lat = -1; busy_ok = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        while (bus.in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                lat = cyc;
                got = bus.out_data;
                break;
            end
            if (cyc <= exp_lat - 2 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic take_output();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_case(input string name, input int n, input int d, input int c, input bit chk_lat);
        logic [W-1:0] got;
        int lat;
        bit busy_ok;
        int exp_m = ref_modexp(c, d, n);
        int exp_l = ref_latency(d);
        do_decrypt(W'(c), exp_l, got, lat, busy_ok);
        n_checks++;
        if (got !== W'(exp_m)) begin
            n_fail++;
            $display("FAIL %s_data n=%0d d=%0d c=%0d got %0d required %0d", name, n, d, c, got, exp_m);
        end
        if (chk_lat) begin
            n_checks++;
            if (lat != exp_l || !busy_ok) begin
                n_fail++;
                $display("FAIL %s_latency got %0d busy_ok=%0d required %0d busy_ok=1", name, lat, busy_ok, exp_l);
            end
        end
        $display("txn %s n=%0d d=%0d c=%0d m=%0d lat=%0d", name, n, d, c, got, lat);
        take_output();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.key_ready, bus.key_err, bus.key_loaded, bus.in_ready, bus.out_valid, bus.busy} !== 6'b0
            || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_hold kr,ke,kl,ir,ov,bz=%b%b%b%b%b%b od=%0d required 000000 od=0",
                     bus.key_ready, bus.key_err, bus.key_loaded, bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.key_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle key_ready=%b in_ready=%b key_loaded=%b required 1 0 0",
                     bus.key_ready, bus.in_ready, bus.key_loaded);
        end
        $display("txn reset done");
    endtask

    task automatic test_basic();
        load_key(8'd33, 8'd7);
        n_checks++;
        if (bus.key_loaded !== 1'b1 || bus.key_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_key key_loaded=%b key_err=%b in_ready=%b required 1 0 1",
                     bus.key_loaded, bus.key_err, bus.in_ready);
        end
        run_case("basic_c31", 33, 7, 31, 1'b1);
    endtask

    task automatic test_reduce_boundaries();
        run_case("c64", 33, 7, 64, 1'b1);
        run_case("c0", 33, 7, 0, 1'b0);
        run_case("c66", 33, 7, 66, 1'b0);
    endtask

    task automatic test_exponent_edges();
        load_key(8'd143, 8'd0);
        run_case("d0", 143, 0, 200, 1'b1);
        load_key(8'd143, 8'd1);
        run_case("d1", 143, 1, 200, 1'b1);
    endtask

    task automatic test_key_err();
        load_key(8'd1, 8'd5);
        n_checks++;
        if (bus.key_err !== 1'b1 || bus.key_loaded !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL key_err_n1 key_err=%b key_loaded=%b in_ready=%b required 1 0 0",
                     bus.key_err, bus.key_loaded, bus.in_ready);
        end
        $display("txn key n=1 err=%b loaded=%b", bus.key_err, bus.key_loaded);
        load_key(8'd33, 8'd7);
        n_checks++;
        if (bus.key_err !== 1'b0 || bus.key_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL key_err_clear key_err=%b key_loaded=%b required 0 1", bus.key_err, bus.key_loaded);
        end
        $display("txn key n=33 err=%b loaded=%b", bus.key_err, bus.key_loaded);
    endtask

    task automatic test_stall();
        logic [W-1:0] got;
        int lat;
        bit busy_ok;
        int bad = 0;
        do_decrypt(8'd31, ref_latency(7), got, lat, busy_ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.key_valid = 1'b1; bus.key_n = 8'd50; bus.key_d = 8'd3;
            bus.in_valid  = 1'b1; bus.in_data = 8'd9;
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd4 || bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++; bad++;
                $display("FAIL stall_hold cyc=%0d ov=%b od=%0d kr=%b ir=%b required 1 4 0 0",
                         i, bus.out_valid, bus.out_data, bus.key_ready, bus.in_ready);
            end
        end
        @(negedge clk);
        bus.key_valid = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.key_ready !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release ov=%b kr=%b ir=%b required 0 1 1", bus.out_valid, bus.key_ready, bus.in_ready);
        end
        $display("txn stall m=%0d held 20 cycles bad=%0d", got, bad);
        run_case("after_stall", 33, 7, 31, 1'b1);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'd31;
        while (bus.in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (W + 30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.key_ready, bus.key_err, bus.key_loaded, bus.in_ready, bus.out_valid, bus.busy} !== 6'b0
            || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid kr,ke,kl,ir,ov,bz=%b%b%b%b%b%b od=%0d required 000000 od=0",
                     bus.key_ready, bus.key_err, bus.key_loaded, bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset mid-EXP");
        load_key(8'd33, 8'd7);
        run_case("post_reset", 33, 7, 31, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int n = int'($urandom_range(2, 255));
            int d = int'($urandom_range(0, 255));
            int c = int'($urandom_range(0, 255));
            if (i == 0) d = 255;
            load_key(W'(n), W'(d));
            run_case("rand", n, d, c, 1'b1);
        end
    endtask

    initial begin
        bus.key_valid = 1'b0; bus.key_n = '0; bus.key_d = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_reduce_boundaries();
        test_exponent_edges();
        test_key_err();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_modexp_decryptor.md
Name: rsa_modexp_decryptor

Overview:
- Consumer end of the key generator. Holds a private key (modulus n, exponent d) loaded from the key path.
- Decrypts one W-bit ciphertext at a time: m = c^d mod n.
- Uses right-to-left square-and-multiply with bit-serial interleaved modular multiplication, so no wide multiplier or divider is needed.
- Sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides.

Parameters:
- W, 8, data/modulus/exponent width in bits; all arithmetic widths derive from W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  key load request.
- key_n  in  W  modulus n.
- key_d  in  W  private exponent d.
- key_ready  out  1  key can be accepted (state IDLE).
- key_err  out  1  last key attempt was rejected (n<2); sticky until the next accepted key.
- key_loaded  out  1  a valid key is held.
- in_valid  in  1  ciphertext valid.
- in_data  in  W  ciphertext c (any value; reduced mod n internally).
- in_ready  out  1  = (state==IDLE) && key_loaded.
- out_valid  out  1  plaintext valid.
- out_data  out  W  plaintext m.
- out_ready  in  1  sink accepts plaintext.
- busy  out  1  high in REDUCE or EXP.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: key_ready=0 during reset then 1 in IDLE; key_err=0, key_loaded=0, in_ready=0, out_valid=0, out_data=0, busy=0. Internal n, d, acc, base, result are all 0.
- FSM states: IDLE, REDUCE, EXP, DONE.
- IDLE, key load: when key_valid && key_ready,
  - n<2: key_err<=1, key_loaded<=0.
  - otherwise: n and d latched, key_loaded<=1, key_err<=0.
  - key_valid outside IDLE is ignored; key_ready=0 there.
- IDLE, ciphertext accept: when in_valid && in_ready, latch c, set result<=1, go to REDUCE.
  - Key load and ciphertext accept cannot both happen in one cycle: in_ready requires key_loaded from a previous cycle; key has priority.
- Modmul(a,b) (interleaved, W cycles, MSB of a first):
  - acc' = 2*acc + (a_i ? b : 0); then subtract n while acc' >= n (at most 2 subtractions).
  - acc is W+2 bits wide.
  - Precondition: b<n and acc<n at every step.
- REDUCE: W cycles computing base = modmul(c,1) = c mod n. The operand b=1 is valid because n>=2. Then go to EXP with bit index 0.
- EXP: W iterations, LSB of d first, W cycles each. Two modmul units run in parallel:
  - result <= d_k ? modmul(result, base) : result
  - base <= modmul(base, base)
  - After bit W-1 go to DONE. Constant time: all bits are processed regardless of value.
- DONE:
  - out_valid=1 and out_data=result, held stable until out_ready is sampled high.
  - The handshake edge returns to IDLE and clears out_valid.
- Latency: out_valid rises exactly W + W*W + 1 cycles after the accept edge (73 for W=8). Throughput is one result per 73 + handshake cycles.
- Boundary cases:
  - d=0 gives 1.
  - c multiple of n gives 0.
  - c >= n is handled by REDUCE.
  - out_ready held low stalls indefinitely with no data change.
  - reset mid-REDUCE/EXP/DONE aborts the operation, drops the result and clears the key (key_loaded=0).

Optional Feature:
- Macro: MODEXP_EARLY_EXIT_EN.
- Defined: EXP ends after processing the highest set bit of d. Latency = W + W*(msb(d)+1) + 1. For d=0, EXP is skipped entirely: DONE follows REDUCE and out_data=1 (latency W+1).
- Undefined: fixed constant-time latency of W + W*W + 1 for every d.

Test Plan:
- Load n=33, d=7; send c=31 -> out_data=4, out_valid exactly 73 cycles after accept; busy high throughout.
- Same key; send c=64 (>=n) -> out_data=4; send c=0 -> out_data=0; send c=66 -> out_data=0.
- Load n=143, d=0; send c=200 -> out_data=1. Load d=1, send c=200 -> out_data=57.
- Load n=1 -> key_err=1, key_loaded=0, in_ready=0. Then load n=33, d=7 -> key_err=0, key_loaded=1.
- Result 4 pending, out_ready low 20 cycles -> out_valid/out_data=4 stable; key_valid and in_valid ignored; out_ready high -> IDLE next cycle.
- Assert reset at cycle 30 of EXP -> next cycle all outputs at reset values, key_loaded=0; new key plus c=31 -> 4.
